// File: rtl/remote_comm_if.sv
// remote_comm_if: command/response bundle between a host and the remote_comm UART commander
//   snd_cmd  host -> dut  one-cycle transmit request
//   cmd      host -> dut  16-bit command word
//   rx       line -> dut  UART serial in from robot (asynchronous)
//   cmd_snt  dut -> host  one-cycle pulse, both bytes fully on the line
//   tx       dut -> line  UART serial out to robot, idle high
//   resp     dut -> host  last valid response byte
//   resp_rdy dut -> host  a valid response is held in resp
//   resp_tmo dut -> host  response watchdog expired
interface remote_comm_if;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        cmd_snt;
    logic        tx;
    logic        rx;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        resp_tmo;
    modport slave  (input snd_cmd, cmd, rx, output cmd_snt, tx, resp, resp_rdy, resp_tmo);
    modport master (output snd_cmd, cmd, rx, input cmd_snt, tx, resp, resp_rdy, resp_tmo);
endinterface

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two 8N1 UART bytes (high first) and receives 1-byte responses
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  remote_comm_if.slave: snd_cmd/cmd in, cmd_snt/tx out, rx in, resp/resp_rdy/resp_tmo out
//   Optional macro RESP_TIMEOUT_EN adds a response watchdog driving resp_tmo (tied 0 otherwise).
module remote_comm #(
    parameter int BAUD_DIV   = 434,
    parameter int TMO_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    remote_comm_if.slave bus
);
    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    if (BAUD_DIV < 4 || TMO_CYCLES < 1) begin : g_bad_cfg
        $error("remote_comm: BAUD_DIV must be >= 4 and TMO_CYCLES >= 1");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     r_tx_state, w_tx_state_nxt;
    logic [15:0]   r_shadow;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_cmd_snt, w_cmd_snt_nxt;
    logic          w_accept;
    logic [7:0]    w_tx_byte;

    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_sh, w_rx_sh_nxt;
    logic [7:0]    r_resp;
    logic          r_resp_rdy;
    logic          w_rdy_set;

    assign w_tx_byte = (r_tx_state == TX_HIGH) ? r_shadow[15:8] : r_shadow[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_shadow   <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_tx       <= 1'b1;
            r_cmd_snt  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_shadow   <= w_accept ? bus.cmd : r_shadow;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_cmd_snt  <= w_cmd_snt_nxt;
        end
    end

    // TX is registered, so the value for the next bit is chosen when the current one ends.
    // After the HIGH stop bit the LOW start bit follows directly.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_baud_nxt     = r_baud;
        w_bit_nxt      = r_bit;
        w_tx_nxt       = r_tx;
        w_cmd_snt_nxt  = 1'b0;
        w_accept       = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.snd_cmd) begin
                    w_accept       = 1'b1;
                    w_tx_state_nxt = TX_HIGH;
                    w_baud_nxt     = '0;
                    w_bit_nxt      = '0;
                    w_tx_nxt       = 1'b0;
                end
            end
            TX_HIGH, TX_LOW: begin
                w_baud_nxt = r_baud + 1'b1;
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = r_bit + 4'd1;
                    w_tx_nxt   = (r_bit == 4'd8) ? 1'b1 : w_tx_byte[r_bit[2:0]];
                    if (r_bit == 4'd9) begin
                        w_bit_nxt      = '0;
                        w_tx_state_nxt = (r_tx_state == TX_HIGH) ? TX_LOW : TX_IDLE;
                        w_tx_nxt       = (r_tx_state == TX_LOW);
                        w_cmd_snt_nxt  = (r_tx_state == TX_LOW);
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_resp     <= '0;
            r_resp_rdy <= 1'b0;
        end else begin
            r_rx_s1    <= bus.rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_resp     <= w_rdy_set ? r_rx_sh : r_resp;
            r_resp_rdy <= w_rdy_set | (r_resp_rdy & ~w_accept);
        end
    end

    // r_rx_s3 is the previous synchronized sample, used only to see the falling start edge.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_sh_nxt    = r_rx_sh;
        w_rdy_set      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_s3 && !r_rx_s2) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BAUD_LAST) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
                    w_rx_bit_nxt = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BAUD_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    w_rdy_set      = r_rx_s2;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

`ifdef RESP_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_wd_run;
    logic        r_resp_tmo;
    logic        w_wd_hit;

    // The cmd_snt cycle counts as cycle 0, so resp_tmo rises TMO_CYCLES cycles after the pulse.
    assign w_wd_hit = r_wd_run && !r_cmd_snt && !w_rdy_set && r_wd_cnt == 32'(TMO_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt   <= '0;
            r_wd_run   <= 1'b0;
            r_resp_tmo <= 1'b0;
        end else begin
            r_wd_cnt   <= r_cmd_snt ? 32'd1 : (r_wd_run ? r_wd_cnt + 32'd1 : r_wd_cnt);
            r_wd_run   <= r_cmd_snt | (r_wd_run & ~w_rdy_set & ~w_wd_hit);
            r_resp_tmo <= w_accept ? 1'b0 : (r_resp_tmo | w_wd_hit);
        end
    end

    assign bus.resp_tmo = r_resp_tmo;
`else
    assign bus.resp_tmo = 1'b0;
`endif

    assign bus.tx       = r_tx;
    assign bus.cmd_snt  = r_cmd_snt;
    assign bus.resp     = r_resp;
    assign bus.resp_rdy = r_resp_rdy;
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: table-driven transmit vectors plus directed receive, reset and watchdog sequences
module tb_remote_comm;
    localparam int B   = 16;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   first;
    int   cnt;

    remote_comm_if bus();

    remote_comm #(.BAUD_DIV(B), .TMO_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [19:0] line;
        bit          inject;
    } tx_vec_t;

    tx_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] c);
        bus.snd_cmd = 1'b1;
        bus.cmd     = c;
        tick();
        bus.snd_cmd = 1'b0;
        bus.cmd     = 16'h1234;
    endtask

    task automatic wait_snt(input int exp_n);
        int n;
        n = 0;
        while (!bus.cmd_snt && n < 400) begin
            tick();
            n++;
        end
        check("cmd_snt arrival", bus.cmd_snt, 1);
        if (exp_n >= 0) check("cmd_snt latency", n, exp_n);
    endtask

    task automatic run_tx(input tx_vec_t v);
        int bad;
        int early;
        bad   = 0;
        early = 0;
        accept(v.cmd);
        for (int k = 0; k < 20 * B; k++) begin
            if (k % B == 0) bad = 0;
            if (bus.tx !== v.line[19 - k / B]) bad++;
            if (bus.cmd_snt) early++;
            if (v.inject && k == 50) begin
                bus.snd_cmd = 1'b1;
                bus.cmd     = 16'hFFFF;
            end
            tick();
            bus.snd_cmd = 1'b0;
            if (k % B == B - 1) check($sformatf("tx %04h bit %0d wrong cycles", v.cmd, k / B), bad, 0);
        end
        check($sformatf("tx %04h early cmd_snt", v.cmd), early, 0);
        check($sformatf("tx %04h cmd_snt at 320", v.cmd), bus.cmd_snt, 1);
        check($sformatf("tx %04h line idle", v.cmd), bus.tx, 1);
        tick();
        check($sformatf("tx %04h cmd_snt one cycle", v.cmd), bus.cmd_snt, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int acc_k, output int rise);
        logic [9:0] f;
        f    = {stop, b, 1'b0};
        rise = -1;
        for (int k = 0; k < 10 * B; k++) begin
            bus.rx = f[k / B];
            if (k == acc_k) bus.snd_cmd = 1'b1;
            tick();
            bus.snd_cmd = 1'b0;
            if (bus.resp_rdy && rise < 0) rise = k + 1;
        end
        bus.rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h2A35, 20'b0010101001_0101011001, 1'b0};
        vecs[1] = '{16'h2A35, 20'b0010101001_0101011001, 1'b1};
        vecs[2] = '{16'h00FF, 20'b0000000001_0111111111, 1'b0};
        vecs[3] = '{16'h8001, 20'b0000000011_0100000001, 1'b0};
        bus.snd_cmd = 1'b0;
        bus.cmd     = 16'h0000;
        bus.rx      = 1'b1;
        repeat (3) tick();
        check("reset tx", bus.tx, 1);
        check("reset cmd_snt", bus.cmd_snt, 0);
        check("reset resp", bus.resp, 8'h00);
        check("reset resp_rdy", bus.resp_rdy, 0);
        check("reset resp_tmo", bus.resp_tmo, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) run_tx(vecs[i]);

        accept(16'h0102);
        wait_snt(20 * B);
        accept(16'hFF00);
        check("accept in cmd_snt cycle", bus.tx, 0);
        wait_snt(20 * B);
        tick();

        send_rx(8'hA5, 1'b1, -1, first);
        check("rx latency A5", first, 2 + B / 2 + 9 * B + 1);
        check("rx resp A5", bus.resp, 8'hA5);
        check("rx rdy A5", bus.resp_rdy, 1);
        send_rx(8'h5A, 1'b1, -1, first);
        check("rx resp 5A overwrite", bus.resp, 8'h5A);
        check("rx rdy kept", bus.resp_rdy, 1);
        accept(16'h1111);
        check("rdy cleared by accept", bus.resp_rdy, 0);
        check("resp kept after accept", bus.resp, 8'h5A);
        wait_snt(20 * B);
        tick();

        bus.rx = 1'b0;
        repeat (4) tick();
        bus.rx = 1'b1;
        repeat (40) tick();
        check("glitch no rdy", bus.resp_rdy, 0);
        check("glitch resp", bus.resp, 8'h5A);
        send_rx(8'hC3, 1'b1, -1, first);
        check("rx latency after glitch", first, 2 + B / 2 + 9 * B + 1);
        check("rx resp C3", bus.resp, 8'hC3);
        send_rx(8'h5A, 1'b0, -1, first);
        repeat (20) tick();
        check("framing resp kept", bus.resp, 8'hC3);
        check("framing rdy kept", bus.resp_rdy, 1);
        send_rx(8'h3C, 1'b1, -1, first);
        check("rx recovers 3C", bus.resp, 8'h3C);

        accept(16'h2222);
        check("rdy cleared again", bus.resp_rdy, 0);
        wait_snt(20 * B);
        tick();
        send_rx(8'h96, 1'b1, 2 + B / 2 + 9 * B, first);
        check("set vs clear latency", first, 2 + B / 2 + 9 * B + 1);
        check("set wins over clear", bus.resp_rdy, 1);
        check("set wins resp", bus.resp, 8'h96);
        wait_snt(-1);
        tick();

`ifdef RESP_TIMEOUT_EN
        accept(16'h0A0A);
        wait_snt(20 * B);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == TMO - 1) check("tmo not yet", bus.resp_tmo, 0);
            if (k == TMO) check("tmo at limit", bus.resp_tmo, 1);
        end
        accept(16'h0B0B);
        check("tmo cleared by accept", bus.resp_tmo, 0);
        wait_snt(20 * B);
        send_rx(8'hA5, 1'b1, -1, first);
        repeat (TMO + 100) tick();
        check("tmo stopped by response", bus.resp_tmo, 0);
        check("tmo resp A5", bus.resp, 8'hA5);
`else
        accept(16'h0A0A);
        wait_snt(20 * B);
        repeat (TMO + 100) tick();
        check("tmo tied low", bus.resp_tmo, 0);
`endif

        accept(16'h2A00);
        repeat (15 * B + 4) tick();
        check("low byte bit 5 before rst", bus.tx, 0);
        rst = 1'b1;
        tick();
        check("rst mid-frame tx", bus.tx, 1);
        check("rst mid-frame cmd_snt", bus.cmd_snt, 0);
        check("rst mid-frame resp_rdy", bus.resp_rdy, 0);
        check("rst mid-frame resp", bus.resp, 8'h00);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (bus.cmd_snt || !bus.tx) cnt++;
        end
        check("no activity after rst", cnt, 0);
        run_tx(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/remote_comm.md
# remote_comm

BLE-side command transmitter and response receiver, the opposite end of the robot's UART command link. Takes a 16-bit command from a host or testbench and serializes it as two 8N1 UART bytes, high byte first. Independently receives the robot's single-byte response: 0xA5 (done) or 0x5A (in progress). Used as the remote controller model in full-chip simulation and as the FPGA-side commander on the demo board.

## Interface
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4
- TMO_CYCLES, 50_000_000, response watchdog limit in cycles (used only with RESP_TIMEOUT_EN)

- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous active-high reset
- snd_cmd  in  1  one-cycle request to transmit cmd
- cmd  in  16  command word, sampled on accepted snd_cmd
- cmd_snt  out  1  one-cycle pulse when both bytes are fully on the line
- TX  out  1  UART serial out to robot, idle high
- RX  in  1  UART serial in from robot, asynchronous
- resp  out  8  last valid response byte
- resp_rdy  out  1  level, a valid response is held in resp
- resp_tmo  out  1  level, response watchdog expired

## Operation
- Reset values: TX=1, cmd_snt=0, resp=8'h00, resp_rdy=0, resp_tmo=0. RX synchronizer flops reset to 1.
- **Transmit FSM**
  - States: IDLE → HIGH → LOW → IDLE.
  - In IDLE, snd_cmd latches cmd into a 16-bit shadow register and moves to HIGH.
  - In HIGH and LOW, a 10-bit frame is shifted out LSB first: start 0, data[7:0], stop 1. HIGH sends cmd[15:8]; LOW sends cmd[7:0].
  - The LOW start bit immediately follows the HIGH stop bit, with no idle gap.
  - snd_cmd is ignored outside IDLE. cmd changes after acceptance have no effect.
  - Baud counter counts 0..BAUD_DIV-1; bit counter counts 0..9 per frame.
- **Receive path**
  - Runs independently of transmit.
  - RX passes through two flops. A start is a 1→0 transition of the synchronized RX while the receiver is idle.
  - After BAUD_DIV/2 cycles the line is re-checked. If it is high, the start was a glitch: abort to idle with no side effects.
  - Otherwise, sample every BAUD_DIV cycles: 8 data bits LSB first, then stop.
  - Stop sampled 1: resp ← shifted byte, resp_rdy ← 1.
  - Stop sampled 0 (framing error): discard the byte; resp and resp_rdy are unchanged.
- **resp_rdy**
  - Cleared when snd_cmd is accepted.
  - If a set and an accept-clear fall in the same cycle, set wins.
  - A new valid byte overwrites resp even if resp_rdy is already 1.
- rst asserted mid-frame aborts both paths immediately. TX goes high the next cycle and any partial byte is lost.

## Timing
- TX falls to the start bit 1 cycle after the accepted snd_cmd; TX is registered.
- Each bit is held exactly BAUD_DIV cycles. A full transaction is 20·BAUD_DIV cycles.
- cmd_snt pulses in the cycle after the final LOW stop bit completes. The FSM is back in IDLE that same cycle, so snd_cmd in that cycle is accepted.
- Receive latency: resp_rdy rises 2 (sync) + BAUD_DIV/2 + 9·BAUD_DIV + 1 cycles after the RX start edge on the pin.
- A back-to-back incoming byte is accepted provided its start edge comes after the stop sample point.

## Configuration
- RESP_TIMEOUT_EN defined:
  - A 32-bit watchdog clears and starts on cmd_snt, and stops on resp_rdy rising.
  - On reaching TMO_CYCLES it sets resp_tmo. resp_tmo is cleared by the next accepted snd_cmd or by rst.
- RESP_TIMEOUT_EN undefined: no watchdog logic, and resp_tmo is tied to 0.

## Test plan
- BAUD_DIV=16, snd_cmd with cmd=16'h2A35 → TX carries frame 0x2A then 0x35 (0,0,1,0,1,0,1,0,0,1 then 0,1,0,1,0,1,1,0,0,1), each bit 16 cycles; cmd_snt pulses exactly 320 cycles after acceptance.
- snd_cmd repulsed 50 cycles into the HIGH byte with cmd=16'hFFFF → ignored; the line still carries 0x2A/0x35 and there is one cmd_snt.
- Drive RX with a valid 0xA5 frame → resp=8'hA5, resp_rdy=1. A following 0x5A frame → resp=8'h5A, resp_rdy still 1. Then snd_cmd → resp_rdy=0 next cycle.
- RX low pulse of 4 cycles → no resp_rdy, receiver idle. A 0x5A frame with stop bit 0 → resp unchanged, resp_rdy unchanged.
- rst asserted at bit 5 of the LOW byte → TX=1 and cmd_snt=0 the next cycle; a fresh snd_cmd afterwards sends a complete 2-byte transaction.
- With RESP_TIMEOUT_EN and TMO_CYCLES=1000: no response after cmd_snt → resp_tmo=1 at cycle 1000. Next snd_cmd → resp_tmo=0. When 0xA5 arrives before 1000 cycles, resp_tmo stays 0.
